// File: rtl/laplace9_approx_5_pkg.sv
// Shared constants and pixel type for the approximate cross-Laplacian filter.
package laplace9_approx_5_pkg;

    localparam int DW          = 8;
    localparam int APPROX_BITS = 5;

    typedef logic [DW-1:0] pixel_t;

    localparam pixel_t PIX_MAX = 8'd255;

endpackage

// File: rtl/laplace9_approx_5_loa_adder.sv
// Lower-part-OR adder: the K LSBs are ORed, the upper part is added exactly
// with a carry guessed from the top approximated bit pair.
module loa_adder #(
    parameter int W = 8,
    parameter int K = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   sum
);

    generate
        if (K == 0) begin : g_exact
            assign sum = {1'b0, a} + {1'b0, b};
        end else begin : g_approx
            logic [K-1:0]   lo_s;
            logic [W-K:0]   hi_s;
            logic           cin_s;

            assign lo_s  = a[K-1:0] | b[K-1:0];
            assign cin_s = a[K-1] & b[K-1];
            assign hi_s  = {1'b0, a[W-1:K]} + {1'b0, b[W-1:K]} + {{(W-K){1'b0}}, cin_s};
            assign sum   = {hi_s, lo_s};
        end
    endgenerate

endmodule

// File: rtl/laplace9_approx_5.sv
// Approximate 5-point Laplacian: s = clamp(4*e - (b+d+f+h), 0, PIX_MAX),
// two register stages, one result per cycle.
module laplace9_approx_5
    import laplace9_approx_5_pkg::*;
#(
    parameter int DW          = laplace9_approx_5_pkg::DW,
    parameter int APPROX_BITS = laplace9_approx_5_pkg::APPROX_BITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] d,
    input  logic [DW-1:0] e,
    input  logic [DW-1:0] f,
    input  logic [DW-1:0] h,
    output logic          out_valid,
    output logic [DW-1:0] s
);

    logic [DW:0]   n1_s;
    logic [DW:0]   n2_s;
    logic [DW:0]   n1_r;
    logic [DW:0]   n2_r;
    logic [DW+1:0] c_r;
    logic          v1_r;
    logic [DW+1:0] nsum_s;
    logic [DW+2:0] diff_s;
    logic [DW-1:0] s_next_s;

    loa_adder #(.W(DW), .K(APPROX_BITS)) u_loa_bd (
        .a   (b),
        .b   (d),
        .sum (n1_s)
    );

    loa_adder #(.W(DW), .K(APPROX_BITS)) u_loa_fh (
        .a   (f),
        .b   (h),
        .sum (n2_s)
    );

    loa_adder #(.W(DW + 1), .K(APPROX_BITS)) u_loa_n (
        .a   (n1_r),
        .b   (n2_r),
        .sum (nsum_s)
    );

    // One extra bit on both operands gives a sign bit; the range cannot wrap.
    assign diff_s = {1'b0, c_r} - {1'b0, nsum_s};

    // Saturate the signed difference into the pixel range.
    always_comb begin
        s_next_s = {DW{1'b0}};
        if (diff_s[DW+2]) begin
            s_next_s = {DW{1'b0}};
        end else if (|diff_s[DW+1:DW]) begin
            s_next_s = {DW{1'b1}};
        end else begin
            s_next_s = diff_s[DW-1:0];
        end
    end

    // Stage 1: neighbour pair sums and scaled centre.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n1_r <= {(DW+1){1'b0}};
            n2_r <= {(DW+1){1'b0}};
            c_r  <= {(DW+2){1'b0}};
            v1_r <= 1'b0;
        end else begin
            n1_r <= n1_s;
            n2_r <= n2_s;
            c_r  <= {e, 2'b00};
            v1_r <= in_valid;
        end
    end

    // Stage 2: registered saturated result and its qualifier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s         <= {DW{1'b0}};
            out_valid <= 1'b0;
        end else begin
            s         <= s_next_s;
            out_valid <= v1_r;
        end
    end

endmodule

// File: tb/tb_laplace9_approx_5.sv
// Directed and streamed checks of the approximate Laplacian filter.
module tb_laplace9_approx_5;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] b, d, e, f, h;
    logic       out_valid;
    logic [7:0] s;

    int total;
    int passes;

    localparam int NSTREAM = 600;
    int exp_q [0:NSTREAM-1];

    laplace9_approx_5 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .b         (b),
        .d         (d),
        .e         (e),
        .f         (f),
        .h         (h),
        .out_valid (out_valid),
        .s         (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int loa_ref(input int x, input int y);
        int lo, hi;
        lo = (x | y) & 31;
        hi = (x >> 5) + (y >> 5) + ((x >> 4) & (y >> 4) & 1);
        return hi * 32 + lo;
    endfunction

    function automatic int lap_ref(input int pb, input int pd, input int pe,
                                   input int pf, input int ph);
        int n, df;
        n  = loa_ref(loa_ref(pb, pd), loa_ref(pf, ph));
        df = 4 * pe - n;
        if (df < 0) return 0;
        else if (df > 255) return 255;
        else return df;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic drive(input int pb, input int pd, input int pe, input int pf,
                         input int ph, input logic v);
        b = pb[7:0];
        d = pd[7:0];
        e = pe[7:0];
        f = pf[7:0];
        h = ph[7:0];
        in_valid = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int rb, rd, re, rf, rh;
        total  = 0;
        passes = 0;
        rst    = 1'b1;
        drive(0, 0, 0, 0, 0, 1'b0);
        step();
        step();
        chk("reset_s", {8'd0, s}, 16'd0);
        chk("reset_valid", {15'd0, out_valid}, 16'd0);
        rst = 1'b0;

        // 1: zeros, valid appears after two clocks
        drive(0, 0, 0, 0, 0, 1'b1);
        step();
        chk("zero_valid_lat1", {15'd0, out_valid}, 16'd0);
        step();
        chk("zero_valid_lat2", {15'd0, out_valid}, 16'd1);
        chk("zero_s", {8'd0, s}, 16'd0);

        // 2: all 100 -> LOA error gives 12
        drive(100, 100, 100, 100, 100, 1'b1);
        step();
        step();
        chk("all100_s", {8'd0, s}, 16'd12);

        // 3: upper saturation
        drive(0, 0, 255, 0, 0, 1'b1);
        step();
        step();
        chk("sat_hi_s", {8'd0, s}, 16'd255);

        // 4: lower clamp
        drive(255, 255, 0, 255, 255, 1'b1);
        step();
        step();
        chk("sat_lo_s", {8'd0, s}, 16'd0);

        // 5a: small exact case
        drive(1, 0, 10, 0, 0, 1'b1);
        step();
        step();
        chk("e10b1_s", {8'd0, s}, 16'd39);

        drive(0, 0, 0, 0, 0, 1'b0);
        step();
        step();
        chk("idle_valid", {15'd0, out_valid}, 16'd0);

        // 5b: back-to-back stream against the reference model
        for (int i = 0; i <= NSTREAM; i++) begin
            if (i < NSTREAM) begin
                rb = (i % 7 == 0) ? 255 : int'($urandom_range(0, 255));
                rd = int'($urandom_range(0, 255));
                re = (i % 5 == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 255));
                rf = (i % 11 == 0) ? 0 : int'($urandom_range(0, 255));
                rh = int'($urandom_range(0, 255));
                exp_q[i] = lap_ref(rb, rd, re, rf, rh);
                drive(rb, rd, re, rf, rh, 1'b1);
            end else begin
                drive(0, 0, 0, 0, 0, 1'b0);
            end
            step();
            if (i >= 1) begin
                chk($sformatf("stream_s[%0d]", i - 1), {8'd0, s}, exp_q[i-1][15:0]);
                chk($sformatf("stream_valid[%0d]", i - 1), {15'd0, out_valid}, 16'd1);
            end
        end

        // 6: reset mid-stream
        drive(0, 0, 200, 0, 0, 1'b1);
        step();
        step();
        chk("pre_rst_s", {8'd0, s}, 16'd255);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_s", {8'd0, s}, 16'd0);
        chk("rst_async_valid", {15'd0, out_valid}, 16'd0);
        #1;
        rst = 1'b0;
        drive(1, 0, 10, 0, 0, 1'b1);
        step();
        chk("post_rst_lat1_valid", {15'd0, out_valid}, 16'd0);
        step();
        chk("post_rst_valid", {15'd0, out_valid}, 16'd1);
        chk("post_rst_s", {8'd0, s}, 16'd39);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
